// File: rtl/time_keeper.sv
`timescale 1ns/1ps
// time_keeper
//   Wall-clock core: divides clk down to a 1 Hz tick and keeps binary
//   hour/min/sec. A button-driven set mode lets the user edit hours and minutes.
//
//   Ports
//     clk, rst     system clock; asynchronous active-high reset
//     mode_btn     one-cycle pulse: RUN -> SET_HOUR -> SET_MIN -> RUN
//     inc_btn      one-cycle pulse: increments the field being edited
//     hour         0..23, binary
//     min, sec     0..59, binary
//     sec_tick     one-cycle pulse each time the prescaler wraps
//     edit_field   0 = RUN, 1 = editing hour, 2 = editing minute
//     blink        display blink enable: 1 in RUN, toggles per tick while editing
module time_keeper #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned PRE_W  = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [4:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       sec_tick,
   output logic [1:0] edit_field,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } state_t;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

   state_t           state;
   state_t           state_nx;
   logic [PRE_W-1:0] pre;
   logic             wrap;

   logic             enter_edit;
   logic             exit_edit;
   logic             run_tick;
   logic             inc_hour;
   logic             inc_min;

   assign wrap = (pre == PRE_LAST);

   // Next state and per-cycle strobes. A mode press always wins over inc.
   always_comb begin
      state_nx   = state;
      enter_edit = 1'b0;
      exit_edit  = 1'b0;
      run_tick   = 1'b0;
      inc_hour   = 1'b0;
      inc_min    = 1'b0;
      case (state)
         RUN: begin
            run_tick = wrap;
            if (mode_btn) begin
               state_nx   = SET_HOUR;
               enter_edit = 1'b1;
            end
         end
         SET_HOUR: begin
            if (mode_btn) state_nx = SET_MIN;
            else          inc_hour = inc_btn;
         end
         SET_MIN: begin
            if (mode_btn) begin
               state_nx  = RUN;
               exit_edit = 1'b1;
            end else begin
               inc_min = inc_btn;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   // The state register is itself the registered edit_field output.
   assign edit_field = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre      <= '0;
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= wrap;
         // Leaving set mode restarts the second so the first tick is a full period away.
         if (wrap || exit_edit) pre <= '0;
         else                   pre <= pre + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour <= '0;
         min  <= '0;
         sec  <= '0;
      end else if (run_tick) begin
         // All carries resolve on one edge: 23:59:59 -> 00:00:00.
         if (sec == 6'd59) begin
            sec <= '0;
            if (min == 6'd59) begin
               min  <= '0;
               hour <= (hour == 5'd23) ? '0 : hour + 5'd1;
            end else begin
               min <= min + 6'd1;
            end
         end else begin
            sec <= sec + 6'd1;
         end
      end else begin
         if (inc_hour) hour <= (hour == 5'd23) ? '0 : hour + 5'd1;
         if (inc_min)  min  <= (min == 6'd59) ? '0 : min + 6'd1;
         if (exit_edit) sec <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            blink <= 1'b1;
      else if (enter_edit)                blink <= 1'b0;
      else if (exit_edit)                 blink <= 1'b1;
      else if (state != RUN && wrap)      blink <= ~blink;
   end

endmodule

// File: tb/tb_time_keeper.sv
`timescale 1ns/1ps
// tb_time_keeper
//   Scoreboard bench: the stimulus process advances a time-of-day reference
//   model (seconds since midnight) and queues the expected outputs for each
//   clock edge; an independent monitor pops and compares after every edge.
module tb_time_keeper;

   localparam int CLK_HZ = 4;
   localparam int PRE_W  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_btn;
   logic       inc_btn;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       sec_tick;
   logic [1:0] edit_field;
   logic       blink;

   time_keeper #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .hour       (hour),
      .min        (min),
      .sec        (sec),
      .sec_tick   (sec_tick),
      .edit_field (edit_field),
      .blink      (blink)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int m;
      int s;
      int tick;
      int ef;
      int bl;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: time of day in seconds, mode 0/1/2, cycle count within the second.
   int   r_t;
   int   r_mode;
   int   r_pre;
   int   r_blink;

   function automatic int r_h();
      return r_t / 3600;
   endfunction

   function automatic int r_m();
      return (r_t / 60) % 60;
   endfunction

   task automatic model_reset();
      r_t     = 0;
      r_mode  = 0;
      r_pre   = 0;
      r_blink = 1;
   endtask

   task automatic compare(input string name, input exp_t e);
      n_vec++;
      if (int'(hour) != e.h || int'(min) != e.m || int'(sec) != e.s ||
          int'(sec_tick) != e.tick || int'(edit_field) != e.ef || int'(blink) != e.bl) begin
         n_err++;
         $display("FAIL %s @%0t: got h=%0d m=%0d s=%0d tick=%0d ef=%0d blink=%0d, want h=%0d m=%0d s=%0d tick=%0d ef=%0d blink=%0d",
                  name, $time, hour, min, sec, sec_tick, edit_field, blink,
                  e.h, e.m, e.s, e.tick, e.ef, e.bl);
      end
   endtask

   // One clock edge of stimulus; called at a falling edge.
   task automatic step(input bit mb, input bit ib);
      exp_t e;
      bit   wrap;
      mode_btn = mb;
      inc_btn  = ib;
      wrap = (r_pre == CLK_HZ - 1);
      case (r_mode)
         0: if (wrap) r_t = (r_t + 1) % 86400;
         1: if (ib && !mb) r_t = ((r_h() + 1) % 24) * 3600 + r_t % 3600;
         default: begin
            if (mb)      r_t = r_t - r_t % 60;
            else if (ib) r_t = r_h() * 3600 + ((r_m() + 1) % 60) * 60 + r_t % 60;
         end
      endcase
      if (r_mode == 2 && mb) r_pre = 0;
      else                   r_pre = (r_pre + 1) % CLK_HZ;
      if (r_mode == 0 && mb)         r_blink = 0;
      else if (r_mode == 2 && mb)    r_blink = 1;
      else if (r_mode != 0 && wrap)  r_blink = 1 - r_blink;
      if (mb) r_mode = (r_mode + 1) % 3;
      e.h = r_h(); e.m = r_m(); e.s = r_t % 60;
      e.tick = wrap ? 1 : 0; e.ef = r_mode; e.bl = r_blink;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   // Monitor: the DUT presents a fresh registered output set after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            compare("cycle", e);
         end
      end
   end

   task automatic check_reset_values(input string name);
      exp_t e;
      e.h = 0; e.m = 0; e.s = 0; e.tick = 0; e.ef = 0; e.bl = 1;
      compare(name, e);
   endtask

   // Asserts rst between edges and checks outputs clear before the next edge.
   task automatic async_reset(input string name);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values(name);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mode_btn = 1'b0;
      inc_btn = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_values("reset_release");

      // Free run: first tick after 4 edges, minute rolls after 240.
      repeat (240) step(1'b0, 1'b0);

      // Reach hour 5, return to RUN, then reset asynchronously.
      step(1'b1, 1'b0);
      while (r_h() != 5) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      async_reset("async_rst_run");

      // Set sequence: hour 3, minute wraps through 0 to 1, then run.
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (61) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);

      // Midnight wrap from 23:59:00.
      step(1'b1, 1'b0);
      while (r_h() != 23) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      while (r_m() != 59) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (60 * CLK_HZ + 4) step(1'b0, 1'b0);

      // Collision, inc lockout in RUN, frozen seconds in SET_HOUR.
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (8 * CLK_HZ) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);

      // Reset mid-edit in SET_MIN at minute 30.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      while (r_m() != 30) step(1'b0, 1'b1);
      async_reset("async_rst_edit");
      repeat (12) step(1'b0, 1'b0);

      // Randomized traffic.
      repeat (3000) step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);

      repeat (3) @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
